pattern_serializer: RTL and testbench
=====================================

# pattern_serializer

Transmit-side companion to the serial pattern detectors: accepts a PAT_W-bit pattern and a repeat count over a valid/ready load handshake, then drives the pattern MSB-first onto a single-bit serial line, one bit per clock, the requested number of times. It sits upstream of a detector's `in` pin and serves as a stimulus/traffic source for framing and sync-word insertion.

## Interface
- PAT_W, 6, pattern width in bits (>= 2)
- CNT_W, 4, repeat-count width

- clk  input  1  clock; all logic on rising edge
- rstn  input  1  reset, synchronous, active-low
- load_valid  input  1  load request
- load_ready  output  1  block can accept a load this cycle
- load_pattern  input  PAT_W  pattern to send; bit PAT_W-1 goes first
- load_reps  input  CNT_W  number of pattern repetitions (0 allowed)
- ser_out  output  1  serial data bit
- ser_valid  output  1  ser_out carries a live bit this cycle
- frame_start  output  1  high on the first bit of each pattern repetition
- done  output  1  one-cycle pulse when the transfer completes

## Operation
- Reset, synchronous, active-low, on clk (rstn sampled at rising edge): state IDLE; load_ready=0 in the reset cycle, 1 in the first cycle after rstn deasserts; ser_out=0, ser_valid=0, frame_start=0, done=0; internal pattern, bit counter and repeat counter cleared.
- All outputs registered; load_ready decoded from the state register (high only in IDLE).
- Acceptance: load_valid && load_ready at a rising edge. load_pattern and load_reps are captured only then. load_valid in any other state is ignored, not queued.
- States:
  - IDLE: on acceptance with load_reps != 0, go to SHIFT with bit index PAT_W-1 and reps_left = load_reps. With load_reps == 0, go to DONE.
  - SHIFT: ser_out = pattern[bit index], ser_valid=1, frame_start=1 when bit index = PAT_W-1. Index decrements each cycle. After bit 0: with the macro, go to PARITY. Otherwise, if reps_left > 1, decrement reps_left, reload index to PAT_W-1 and stay in SHIFT with no gap; if reps_left == 1, go to DONE.
  - PARITY: exists only with the macro. One cycle, ser_out = XOR of all pattern bits (even parity), ser_valid=1, frame_start=0. Then apply the same repeat decision as at the end of SHIFT.
  - DONE: one cycle, done=1, ser_valid=0, load_ready=0. Then go to IDLE.
- ser_out is forced to 0 whenever ser_valid=0.
- Counters: bit index is $clog2(PAT_W) bits wide; reps_left is CNT_W bits wide and cannot wrap, because decrement happens only when reps_left > 1.
- Reset mid-transfer: abort at that edge with no done pulse; the partial pattern is discarded.

## Timing
- Acceptance edge at cycle N: first bit appears (ser_valid=1, frame_start=1) in cycle N+1.
- Repetitions are back-to-back; frame length F = PAT_W, or PAT_W+1 with the macro.
- Last bit in cycle N+reps*F; done in cycle N+reps*F+1; load_ready=1 in cycle N+reps*F+2.
- reps=0: done in cycle N+1; load_ready=1 in cycle N+2.
- Peak throughput is one load per reps*F+2 cycles.

## Configuration
- PATSER_PARITY_EN defined: the PARITY state is compiled in, and an even-parity bit is appended after every repetition (F = PAT_W+1).
- Not defined: there is no PARITY state; frames are exactly PAT_W bits and repetitions abut directly.

## Test plan
- Reset: hold rstn=0 for 3 cycles with load_valid=1 -> all outputs 0, no acceptance; load_ready=1 in the first cycle after release.
- Single send: pattern=6'b110101, reps=1 accepted at N -> ser_out 1,1,0,1,0,1 in N+1..N+6; frame_start only at N+1; done at N+7; load_ready at N+8. Feeding ser_out into the 110101 detector must produce exactly one detection.
- Repeat: pattern=6'b100000, reps=3 -> 18 contiguous valid bits; frame_start at N+1, N+7, N+13; done at N+19. With PATSER_PARITY_EN: 21 valid bits, parity bits equal to 1 at N+7, N+14, N+21, and done at N+22.
- Zero reps and busy load: reps=0 -> no ser_valid, done at N+1. A second load_valid asserted during SHIFT is not accepted, and the captured pattern is unchanged.
- Reset mid-transfer: pattern=6'b110101, reps=2, rstn=0 at N+4 -> all outputs 0 from N+5 onward, no done pulse; a fresh load after release behaves exactly as in the single-send case.

Source files
------------

// File: rtl/pattern_serializer.sv
// Serial pattern source: accepts a pattern and repeat count, then shifts the pattern out MSB-first.
// Define PATSER_PARITY_EN to append an even-parity bit after every repetition.
module pattern_serializer #(
    parameter int PAT_W = 6,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [PAT_W-1:0] load_pattern,
    input  logic [CNT_W-1:0] load_reps,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             done
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

`ifdef PATSER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_reps;
    logic [PAT_W-1:0] r_pat;
    logic             r_ready;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_frame_start;
    logic             r_done;

    state_t           w_state_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0] w_reps_nxt;
    logic [PAT_W-1:0] w_pat_nxt;
    logic             w_accept;
    logic             w_frame_end;
    logic             w_ser_out_nxt;
    logic             w_ser_valid_nxt;
    logic             w_frame_start_nxt;

    assign w_accept = load_valid && r_ready;

    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_reps_nxt        = r_reps;
        w_pat_nxt         = r_pat;
        w_frame_end       = 1'b0;
        w_ser_out_nxt     = 1'b0;
        w_ser_valid_nxt   = 1'b0;
        w_frame_start_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_pat_nxt   = load_pattern;
                    w_reps_nxt  = load_reps;
                    w_idx_nxt   = LAST_IDX;
                    w_state_nxt = (load_reps != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (r_idx == '0) begin
`ifdef PATSER_PARITY_EN
                    w_state_nxt = PARITY;
`else
                    w_frame_end = 1'b1;
`endif
                end else begin
                    w_idx_nxt = r_idx - IDX_W'(1);
                end
            end
`ifdef PATSER_PARITY_EN
            PARITY: w_frame_end = 1'b1;
`endif
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        // Shared end-of-repetition decision; reps_left never drops below 1.
        if (w_frame_end) begin
            if (r_reps > CNT_W'(1)) begin
                w_reps_nxt  = r_reps - CNT_W'(1);
                w_idx_nxt   = LAST_IDX;
                w_state_nxt = SHIFT;
            end else begin
                w_state_nxt = DONE;
            end
        end

        // Outputs are decoded from the next state so they can be registered.
        if (w_state_nxt == SHIFT) begin
            w_ser_valid_nxt   = 1'b1;
            w_ser_out_nxt     = w_pat_nxt[w_idx_nxt];
            w_frame_start_nxt = (w_idx_nxt == LAST_IDX);
        end
`ifdef PATSER_PARITY_EN
        else if (w_state_nxt == PARITY) begin
            w_ser_valid_nxt = 1'b1;
            w_ser_out_nxt   = ^w_pat_nxt;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_reps        <= '0;
            r_pat         <= '0;
            r_ready       <= 1'b0;
            r_ser_out     <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_reps        <= w_reps_nxt;
            r_pat         <= w_pat_nxt;
            r_ready       <= (w_state_nxt == IDLE);
            r_ser_out     <= w_ser_out_nxt;
            r_ser_valid   <= w_ser_valid_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_done        <= (w_state_nxt == DONE);
        end
    end

    assign load_ready  = r_ready;
    assign ser_out     = r_ser_out;
    assign ser_valid   = r_ser_valid;
    assign frame_start = r_frame_start;
    assign done        = r_done;

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: per-cycle queue model plus directed literal checks.
// Honours PATSER_PARITY_EN the same way as the design.
module tb_pattern_serializer;
    localparam int PAT_W = 6;
    localparam int CNT_W = 4;
`ifdef PATSER_PARITY_EN
    localparam int F = PAT_W + 1;
`else
    localparam int F = PAT_W;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic             load_valid;
    logic             load_ready;
    logic [PAT_W-1:0] load_pattern;
    logic [CNT_W-1:0] load_reps;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             done;

    pattern_serializer #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_pattern (load_pattern),
        .load_reps    (load_reps),
        .ser_out      (ser_out),
        .ser_valid    (ser_valid),
        .frame_start  (frame_start),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: on acceptance, the whole transfer is expanded into one expected output word per cycle.
    typedef struct packed {
        logic rdy;
        logic vld;
        logic dat;
        logic fs;
        logic dn;
    } exp_t;

    exp_t exp_q[$];
    exp_t m = '0;

    always @(posedge clk) begin
        exp_t e;
        if (!rstn) begin
            exp_q.delete();
            m <= '0;
        end else begin
            if (load_valid && m.rdy) begin
                for (int r = 0; r < int'(load_reps); r++) begin
                    for (int i = PAT_W - 1; i >= 0; i--) begin
                        e = '0;
                        e.vld = 1'b1;
                        e.dat = load_pattern[i];
                        e.fs  = (i == PAT_W - 1);
                        exp_q.push_back(e);
                    end
`ifdef PATSER_PARITY_EN
                    e = '0;
                    e.vld = 1'b1;
                    e.dat = ^load_pattern;
                    exp_q.push_back(e);
`endif
                end
                e = '0;
                e.dn = 1'b1;
                exp_q.push_back(e);
            end
            if (exp_q.size() != 0) begin
                m <= exp_q.pop_front();
            end else begin
                e = '0;
                e.rdy = 1'b1;
                m <= e;
            end
        end
    end

    int   n_assert = 0;
    int   n_fail   = 0;
    logic bits_q[$];
    int   bcyc_q[$];
    int   fs_q[$];
    int   done_q[$];
    logic [5:0] det_sr = '0;
    int   det_n    = 0;
    int   det_hits = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge, compare against the model and log the serial stream.
    task automatic tick();
        @(negedge clk);
        check1("load_ready", load_ready, m.rdy);
        check1("ser_valid", ser_valid, m.vld);
        check1("ser_out", ser_out, m.dat);
        check1("frame_start", frame_start, m.fs);
        check1("done", done, m.dn);
        if (ser_valid === 1'b1) begin
            bits_q.push_back(ser_out);
            bcyc_q.push_back(cyc);
            det_sr = {det_sr[4:0], ser_out};
            if (det_n < PAT_W) det_n++;
            if (det_n == PAT_W && det_sr == 6'b110101) det_hits++;
        end else begin
            det_n = 0;
        end
        if (frame_start === 1'b1) fs_q.push_back(cyc);
        if (done === 1'b1) done_q.push_back(cyc);
    endtask

    // Returns n = the cycle whose closing edge accepts the load; leaves the bench in cycle n+1.
    task automatic send(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r, output int n);
        int w = 0;
        load_pattern = p;
        load_reps    = r;
        load_valid   = 1'b1;
        while (load_ready !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        checki("send_ready_wait", (w < 40) ? 1 : 0, 1);
        n = cyc;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k = 0;
        while (done_q.size() == d0 && k < budget) begin
            tick();
            k++;
        end
        checki("done_seen", (done_q.size() > d0) ? 1 : 0, 1);
    endtask

    task automatic single_test(input string tag);
        int n, b0, f0, d0, h0;
        logic [F-1:0] exp_bits;
`ifdef PATSER_PARITY_EN
        exp_bits = 7'b1101010;
`else
        exp_bits = 6'b110101;
`endif
        b0 = bits_q.size();
        f0 = fs_q.size();
        d0 = done_q.size();
        h0 = det_hits;
        send(6'b110101, 4'd1, n);
        wait_done(d0, 40);
        tick();
        check1({tag, "_ready_after_done"}, load_ready, 1'b1);
        checki({tag, "_nbits"}, bits_q.size() - b0, F);
        for (int i = 0; i < F; i++) begin
            if (b0 + i < bits_q.size()) begin
                check1({tag, "_bit"}, bits_q[b0 + i], exp_bits[F - 1 - i]);
                checki({tag, "_bit_cycle"}, bcyc_q[b0 + i], n + 1 + i);
            end
        end
        checki({tag, "_nframes"}, fs_q.size() - f0, 1);
        if (fs_q.size() > f0) checki({tag, "_frame_cycle"}, fs_q[f0], n + 1);
        if (done_q.size() > d0) checki({tag, "_done_cycle"}, done_q[d0], n + F + 1);
        checki({tag, "_detections"}, det_hits - h0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, b0, f0, d0;
        logic [3*F-1:0] rep_bits;
        logic [2*F-1:0] busy_bits;
`ifdef PATSER_PARITY_EN
        rep_bits  = 21'b1000001_1000001_1000001;
        busy_bits = 14'b1101010_1101010;
`else
        rep_bits  = 18'b100000_100000_100000;
        busy_bits = 12'b110101_110101;
`endif

        // Reset held with a pending load request.
        rstn         = 1'b0;
        load_valid   = 1'b1;
        load_pattern = 6'b111111;
        load_reps    = 4'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("rst_ready", load_ready, 1'b0);
            check1("rst_valid", ser_valid, 1'b0);
            check1("rst_out", ser_out, 1'b0);
            check1("rst_fs", frame_start, 1'b0);
            check1("rst_done", done, 1'b0);
        end
        rstn       = 1'b1;
        load_valid = 1'b0;
        tick();
        check1("ready_after_rst", load_ready, 1'b1);
        check1("no_valid_after_rst", ser_valid, 1'b0);

        single_test("single");

        // Three back-to-back repetitions.
        b0 = bits_q.size();
        f0 = fs_q.size();
        d0 = done_q.size();
        send(6'b100000, 4'd3, n);
        wait_done(d0, 80);
        checki("rep_nbits", bits_q.size() - b0, 3 * F);
        for (int i = 0; i < 3 * F; i++) begin
            if (b0 + i < bits_q.size()) begin
                check1("rep_bit", bits_q[b0 + i], rep_bits[3 * F - 1 - i]);
                checki("rep_bit_cycle", bcyc_q[b0 + i], n + 1 + i);
            end
        end
        checki("rep_nframes", fs_q.size() - f0, 3);
        for (int k = 0; k < 3; k++) begin
            if (f0 + k < fs_q.size()) checki("rep_frame_cycle", fs_q[f0 + k], n + 1 + k * F);
        end
        if (done_q.size() > d0) checki("rep_done_cycle", done_q[d0], n + 3 * F + 1);

        // Zero repetitions.
        tick();
        b0 = bits_q.size();
        d0 = done_q.size();
        send(6'b101010, 4'd0, n);
        wait_done(d0, 10);
        if (done_q.size() > d0) checki("zero_done_cycle", done_q[d0], n + 1);
        tick();
        check1("zero_ready", load_ready, 1'b1);
        tick();
        checki("zero_nbits", bits_q.size() - b0, 0);

        // Load request while busy must be dropped.
        b0 = bits_q.size();
        d0 = done_q.size();
        send(6'b110101, 4'd2, n);
        load_valid   = 1'b1;
        load_pattern = 6'b001100;
        load_reps    = 4'd5;
        for (int i = 0; i < 4; i++) tick();
        load_valid = 1'b0;
        wait_done(d0, 40);
        checki("busy_nbits", bits_q.size() - b0, 2 * F);
        for (int i = 0; i < 2 * F; i++) begin
            if (b0 + i < bits_q.size()) check1("busy_bit", bits_q[b0 + i], busy_bits[2 * F - 1 - i]);
        end
        if (done_q.size() > d0) checki("busy_done_cycle", done_q[d0], n + 2 * F + 1);
        for (int i = 0; i < 6; i++) tick();
        checki("busy_no_requeue", bits_q.size() - b0, 2 * F);

        // Reset in the middle of a transfer.
        b0 = bits_q.size();
        d0 = done_q.size();
        send(6'b110101, 4'd2, n);
        tick();
        tick();
        tick();
        rstn = 1'b0;
        tick();
        checki("mid_rst_cycle", cyc, n + 5);
        check1("mid_rst_valid", ser_valid, 1'b0);
        check1("mid_rst_out", ser_out, 1'b0);
        check1("mid_rst_fs", frame_start, 1'b0);
        check1("mid_rst_done", done, 1'b0);
        tick();
        rstn = 1'b1;
        tick();
        checki("mid_nbits", bits_q.size() - b0, 4);
        for (int i = 0; i < 4; i++) begin
            if (b0 + i < bits_q.size()) check1("mid_bit", bits_q[b0 + i], (i == 2) ? 1'b0 : 1'b1);
        end
        checki("mid_no_done", done_q.size() - d0, 0);
        check1("mid_ready_after_rst", load_ready, 1'b1);

        single_test("after_rst");

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
